// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: ALU-control decode, single-cycle logic/arith ops and an iterative
// shift-add multiplier / restoring divider that write HI/LO, behind valid/ready handshakes.
//
// state | meaning
// IDLE  | accepting ops or holding a finished result for the consumer
// MUL   | one shift-add step per cycle on operand magnitudes
// DIV   | one restoring-subtract step per cycle on operand magnitudes
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             unsupported,
    output logic             div_by_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_BAD
    } op_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]    work_hi_q, work_hi_d, work_lo_q, work_lo_d, opb_q, opb_d;
    logic                neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                zero_q, zero_d, unsup_q, unsup_d, dbz_q, dbz_d;
    logic                out_valid_q, out_valid_d;

    op_e                 op;
    logic [WIDTH-1:0]    alu_res;
    logic                accept, signed_op, neg_a, neg_b;
    logic [WIDTH-1:0]    mag_a, mag_b;

    logic [WIDTH:0]      mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0]    mul_hi, mul_lo, div_hi, div_lo;
    logic                div_ok;
    logic [2*WIDTH-1:0]  prod, prod_fix;
    logic [WIDTH-1:0]    quot_fix, rem_fix;

    always_comb begin
        op = OP_BAD;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_AND;
            default: begin
                case (funct)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
                    6'b011000: op = OP_MULT;
                    6'b011001: op = OP_MULTU;
                    6'b011010: op = OP_DIV;
                    6'b011011: op = OP_DIVU;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    default:   op = OP_BAD;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign neg_a     = signed_op && src_a[WIDTH-1];
    assign neg_b     = signed_op && src_b[WIDTH-1];
    assign mag_a     = neg_a ? -src_a : src_a;
    assign mag_b     = neg_b ? -src_b : src_b;

    // Multiply: {work_hi, work_lo} holds partial product above the unconsumed multiplier bits.
    assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], work_lo_q[WIDTH-1:1]};

    // Divide: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
    assign div_sh   = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_ok   = !div_diff[WIDTH];
    assign div_hi   = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lo   = {work_lo_q[WIDTH-2:0], div_ok};

    assign prod     = {mul_hi, mul_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -div_lo : div_lo;
    assign rem_fix  = neg_rem_q ? -div_hi : div_hi;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        neg_rem_d   = neg_rem_q;
        result_d    = result_q;
        zero_d      = zero_q;
        unsup_d     = unsup_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    zero_d  = 1'b0;
                    unsup_d = 1'b0;
                    dbz_d   = 1'b0;
                    cnt_d   = '0;
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d     = MUL;
                            work_hi_d   = '0;
                            work_lo_d   = mag_b;
                            opb_d       = mag_a;
                            neg_d       = neg_a ^ neg_b;
                            out_valid_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b == '0) begin
                                hi_d        = src_a;
                                lo_d        = '1;
                                result_d    = '1;
                                dbz_d       = 1'b1;
                                out_valid_d = 1'b1;
                            end else begin
                                state_d     = DIV;
                                work_hi_d   = '0;
                                work_lo_d   = mag_a;
                                opb_d       = mag_b;
                                neg_d       = neg_a ^ neg_b;
                                neg_rem_d   = neg_a;
                                out_valid_d = 1'b0;
                            end
                        end
                        default: begin
                            result_d    = alu_res;
                            zero_d      = (alu_res == '0);
                            unsup_d     = (op == OP_BAD);
                            out_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                work_hi_d = mul_hi;
                work_lo_d = mul_lo;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    hi_d        = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d        = prod_fix[WIDTH-1:0];
                    result_d    = prod_fix[WIDTH-1:0];
                    zero_d      = (prod_fix[WIDTH-1:0] == '0);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DIV: begin
                work_hi_d = div_hi;
                work_lo_d = div_lo;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    hi_d        = rem_fix;
                    lo_d        = quot_fix;
                    result_d    = quot_fix;
                    zero_d      = (quot_fix == '0);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            unsup_q     <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            work_hi_q   <= work_hi_d;
            work_lo_q   <= work_lo_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            neg_rem_q   <= neg_rem_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            unsup_q     <= unsup_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign busy        = (state_q == MUL) || (state_q == DIV);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign unsupported = unsup_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Randomized and directed checks of alu_muldiv_unit against an arithmetic reference model.
module tb_alu_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, out_valid, out_ready;
    logic          zero, unsupported, div_by_zero, busy;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [W-1:0]  src_a, src_b, result;

    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  m_hi, m_lo, last_res;
    logic [5:0]    tbl [0:17] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                  6'b100111, 6'b101010, 6'b101011, 6'b011000, 6'b011001,
                                  6'b011010, 6'b011011, 6'b010000, 6'b010010, 6'b111111,
                                  6'b000000, 6'b100001, 6'b011100};

    alu_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .unsupported(unsupported), .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero like the spec.
    task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] r, output logic u,
                         output logic d, output logic lng);
        longint sa, sb, q, rm;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; u = 1'b0; d = 1'b0; lng = 1'b0;
        if (op == 2'b00)      r = a + b;
        else if (op == 2'b01) r = a - b;
        else if (op == 2'b11) r = a & b;
        else begin
            case (fn)
                6'b100000: r = a + b;
                6'b100010: r = a - b;
                6'b100100: r = a & b;
                6'b100101: r = a | b;
                6'b100110: r = a ^ b;
                6'b100111: r = ~(a | b);
                6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
                6'b101011: r = (a < b) ? 32'd1 : 32'd0;
                6'b011000, 6'b011001: begin
                    if (fn[0]) p = {32'b0, a} * {32'b0, b};
                    else       p = sa * sb;
                    m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lng = 1'b1;
                end
                6'b011010, 6'b011011: begin
                    if (b == '0) begin
                        m_hi = a; m_lo = '1; r = m_lo; d = 1'b1;
                    end else begin
                        lng = 1'b1;
                        if (fn[0]) begin
                            m_lo = a / b; m_hi = a % b;
                        end else begin
                            q = sa / sb; rm = sa % sb;
                            m_lo = q[31:0]; m_hi = rm[31:0];
                        end
                        r = m_lo;
                    end
                end
                6'b010000: r = m_hi;
                6'b010010: r = m_lo;
                default:   u = 1'b1;
            endcase
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic eu, ed, el, rdy_in_busy;
        int lat, nbusy;
        @(negedge clk);
        check("ready_idle", in_ready, 1);
        alu_op = op; funct = fn; src_a = a; src_b = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        model(op, fn, a, b, er, eu, ed, el);
        @(negedge clk);
        in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
        lat = 1; nbusy = 0; rdy_in_busy = 1'b0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            if (in_ready) rdy_in_busy = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, el ? W + 1 : 1);
        if (el) begin
            check("busy_cycles", nbusy, W);
            check("ready_while_busy", rdy_in_busy, 0);
        end
        check("result", result, er);
        check("zero", zero, (er == '0));
        check("unsupported", unsupported, eu);
        check("div_by_zero", div_by_zero, ed);
        last_res = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, er);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_clear", out_valid, 0);
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [1:0] rop;
        logic [5:0] rfn;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct = 6'b0; src_a = '0; src_b = '0;
        m_hi = '0; m_lo = '0; last_res = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {zero, unsupported, div_by_zero, busy}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0);
        check("slt_neg", last_res, 1);
        run_op(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 0);
        check("sltu_big", last_res, 0);
        run_op(2'b10, 6'b011000, -32'd3, 32'd7, 0);
        check("mult_lo", last_res, 32'hFFFF_FFEB);
        run_op(2'b10, 6'b010000, 32'd0, 32'd0, 0);
        check("mult_hi", last_res, 32'hFFFF_FFFF);
        run_op(2'b10, 6'b011011, 32'd100, 32'd7, 0);
        check("divu_q", last_res, 14);
        run_op(2'b10, 6'b010000, 32'd0, 32'd0, 0);
        check("divu_r", last_res, 2);
        run_op(2'b10, 6'b011010, -32'd7, 32'd2, 0);
        check("div_q", last_res, 32'hFFFF_FFFD);
        run_op(2'b10, 6'b010000, 32'd0, 32'd0, 0);
        check("div_r", last_res, 32'hFFFF_FFFF);
        run_op(2'b10, 6'b011010, 32'd5, 32'd0, 0);
        check("dbz_lo", last_res, 32'hFFFF_FFFF);
        run_op(2'b10, 6'b010000, 32'd0, 32'd0, 0);
        check("dbz_hi", last_res, 5);
        run_op(2'b00, 6'b000000, 32'd3, 32'd4, 5);
        check("add_held", last_res, 7);
        run_op(2'b10, 6'b111111, 32'd9, 32'd9, 0);
        run_op(2'b10, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_q", last_res, 32'h8000_0000);
        run_op(2'b10, 6'b010000, 32'd0, 32'd0, 0);
        check("div_ovf_r", last_res, 0);

        // Reset in the middle of a multiply
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b011001; src_a = 32'd1234; src_b = 32'd5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready", in_ready, 1);
        run_op(2'b10, 6'b010010, 32'd0, 32'd0, 0);
        check("abort_lo", last_res, 0);
        run_op(2'b10, 6'b010000, 32'd0, 32'd0, 0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       rop = 2'b00;
                1:       rop = 2'b01;
                2:       rop = 2'b11;
                default: rop = 2'b10;
            endcase
            rfn = tbl[$urandom_range(0, 17)];
            run_op(rop, rfn, pick_val(), pick_val(), ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
